sound_arbiter: RTL and testbench
================================

SOUND_ARBITER -- requirements
Module: sound_arbiter

Interface
REQ-001 Parameter GOAL_CYC, default 25_000_000, tone length in clk cycles for req_goal and req_sgoal.
REQ-002 Parameter CNT_CYC, default 10_000_000, tone length for req_cnt.
REQ-003 Parameter END_CYC, default 100_000_000, tone length for req_end.
REQ-004 Parameter GAP_CYC, default 5_000_000, silent cycles between tones; legal range >= 1.
REQ-005 clk  input  1  system clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 en  input  1  sound enable (level); 0 mutes and flushes.
REQ-008 req_end  input  1  win/lose jingle request, 1-cycle pulse.
REQ-009 req_goal  input  1  local goal request, 1-cycle pulse.
REQ-010 req_sgoal  input  1  remote (slave) goal request, 1-cycle pulse.
REQ-011 req_cnt  input  1  countdown tick request, 1-cycle pulse.
REQ-012 tone_on  output  1  registered; 1 while a tone plays.
REQ-013 tone_sel  output  2  registered; source of the current tone: 0 cnt, 1 sgoal, 2 goal, 3 end.
REQ-014 grant  output  4  registered one-hot pulse {end,goal,sgoal,cnt}, high for exactly one cycle when a tone starts.
REQ-015 busy  output  1  registered; 1 in PLAY or GAP.

Function
REQ-016 The block SHALL implement states IDLE, PLAY and GAP, with a 32-bit down-counter for tone and gap duration.
REQ-017 Priority SHALL be end > goal > sgoal > cnt, fixed.
REQ-018 In IDLE with en=1, a request (or pending flag) at edge N SHALL give PLAY, tone_on=1, grant pulse and tone_sel at N+1.
REQ-019 tone_on SHALL stay high for exactly the source's *_CYC cycles, then GAP with tone_on=0, busy=1, for exactly GAP_CYC cycles.
REQ-020 At the last GAP cycle, if any pending flag is set, the block SHALL enter PLAY on the next cycle with the highest-priority pending source; otherwise it SHALL enter IDLE.
REQ-021 With several requests in the same cycle, the highest SHALL be granted; the others SHALL be handled per REQ-030/031.
REQ-022 req_end during a PLAY of any other source SHALL abort that tone and start the end tone on the next cycle, with a fresh grant, no gap, and counter reloaded to END_CYC.
REQ-023 req_end during an end tone SHALL NOT restart it.
REQ-024 en=0 SHALL, on the next edge, force IDLE, tone_on=0, busy=0 and clear all pending flags; requests SHALL be ignored while en=0.
REQ-025 tone_sel SHALL hold its last value in GAP and IDLE.
REQ-026 grant SHALL never assert for more than one cycle per tone start.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, counter 0 and pending flags 0, with tone_on=0, tone_sel=0, grant=0 and busy=0.
REQ-028 Reset asserted mid-PLAY or mid-GAP SHALL drop the tone with no further grant.
REQ-029 The first request is accepted on the first edge after rst deasserts.

Configuration
REQ-030 With SOUND_QUEUE_EN defined, each source SHALL have a 1-bit pending flag.
  - A flag is set by a request that is not granted immediately (busy, or lost the same-cycle priority), including a repeat of the source now playing.
  - A flag is cleared when that source is granted.
  - Multiple requests collapse into one flag.
REQ-031 Without SOUND_QUEUE_EN, requests arriving while busy=1, and losing same-cycle requests, SHALL be dropped; REQ-022 preemption SHALL still apply.

Verification
REQ-032 Params GOAL_CYC=4, CNT_CYC=2, END_CYC=6, GAP_CYC=1; req_goal pulse in IDLE at cycle 0 -> grant=0100 at cycle 1; tone_on 1..4; busy 1..5; IDLE at 6.
REQ-033 req_goal and req_cnt in the same cycle, queue on -> goal tone 4 cycles, gap 1, cnt tone 2 cycles with a second grant=0001; queue off -> cnt never granted.
REQ-034 req_end at the 2nd cycle of a goal tone -> next cycle grant=1000, tone_sel=3, tone_on continuous, 6 high cycles.
REQ-035 Three req_sgoal pulses while busy, queue on -> exactly one extra sgoal tone.
REQ-036 en dropped mid-tone -> tone_on=0 and busy=0 next cycle; a pending cnt is not played after en returns.
REQ-037 rst pulsed asynchronously mid-GAP -> all outputs 0 before the next clk edge; req_cnt after release -> grant=0001 one cycle later.

Source files
------------

// File: rtl/sound_arbiter.sv
// sound_arbiter: fixed-priority tone sequencer for the game sound output.
// Sources, highest priority first: end jingle, local goal, remote goal,
// countdown tick. Each tone plays for its source's length and is followed
// by a silent gap before the next tone may start. An end request cuts
// short any other tone immediately.
//
// Optional feature macro: SOUND_QUEUE_EN
//   defined   - each source has a 1-bit pending flag, so requests that are
//               not granted immediately are played later (repeats collapse).
//   undefined - requests that are not granted immediately are dropped.

module sound_arbiter #(
  parameter int unsigned GOAL_CYC = 32'd25_000_000,
  parameter int unsigned CNT_CYC  = 32'd10_000_000,
  parameter int unsigned END_CYC  = 32'd100_000_000,
  parameter int unsigned GAP_CYC  = 32'd5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       req_end,
  input  logic       req_goal,
  input  logic       req_sgoal,
  input  logic       req_cnt,
  output logic       tone_on,
  output logic [1:0] tone_sel,
  output logic [3:0] grant,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

`ifdef SOUND_QUEUE_EN
  localparam logic QUEUE_ON = 1'b1;
`else
  localparam logic QUEUE_ON = 1'b0;
`endif

  // The counter holds the number of cycles still to go after the current
  // one, so a phase of N cycles is loaded with N-1 and ends at zero.
  localparam logic [31:0] L_GOAL = 32'(GOAL_CYC - 32'd1);
  localparam logic [31:0] L_CNT  = 32'(CNT_CYC  - 32'd1);
  localparam logic [31:0] L_END  = 32'(END_CYC  - 32'd1);
  localparam logic [31:0] L_GAP  = 32'(GAP_CYC  - 32'd1);

  // Source bit positions, shared by requests, pending flags and grant.
  localparam int unsigned B_END = 3;

  // Highest-priority request as a one-hot vector (bit 3 = end wins).
  function automatic logic [3:0] f_pick_hi(input logic [3:0] v);
    logic [3:0] r;
    if (v[3]) begin
      r = 4'b1000;
    end else if (v[2]) begin
      r = 4'b0100;
    end else if (v[1]) begin
      r = 4'b0010;
    end else if (v[0]) begin
      r = 4'b0001;
    end else begin
      r = 4'b0000;
    end
    return r;
  endfunction

  // tone_sel code of a one-hot source (code equals the bit index).
  function automatic logic [1:0] f_sel(input logic [3:0] oh);
    logic [1:0] r;
    case (oh)
      4'b1000: r = 2'd3;
      4'b0100: r = 2'd2;
      4'b0010: r = 2'd1;
      4'b0001: r = 2'd0;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  // Counter reload value for the tone of a one-hot source.
  function automatic logic [31:0] f_len(input logic [3:0] oh);
    logic [31:0] r;
    case (oh)
      4'b1000: r = L_END;
      4'b0100: r = L_GOAL;
      4'b0010: r = L_GOAL;
      4'b0001: r = L_CNT;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  state_t      r_state;
  logic [31:0] r_cnt;
  logic [3:0]  r_pend;
  logic        r_tone_on;
  logic [1:0]  r_tone_sel;
  logic [3:0]  r_grant;
  logic        r_busy;

  state_t      w_state_nxt;
  logic [31:0] w_cnt_nxt;
  logic [3:0]  w_pend_nxt;
  logic [3:0]  w_grant_nxt;
  logic [1:0]  w_sel_nxt;
  logic [3:0]  w_req;
  logic [3:0]  w_queued;
  logic [3:0]  w_pick;

  assign w_req = {req_end, req_goal, req_sgoal, req_cnt};

  // Next-state, counter, pending-flag and grant decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = r_pend;
    w_grant_nxt = 4'b0000;
    w_sel_nxt   = r_tone_sel;
    w_pick      = 4'b0000;
    // Everything waiting for service this cycle: old flags plus new
    // requests. Without the queue nothing is ever remembered.
    w_queued    = QUEUE_ON ? (r_pend | w_req) : 4'b0000;

    if (!en) begin
      // Muted: flush everything, ignore requests, keep tone_sel.
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = 32'd0;
      w_pend_nxt  = 4'b0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_pick = f_pick_hi(QUEUE_ON ? w_queued : w_req);
        end
        ST_PLAY: begin
          if (req_end && (r_tone_sel != 2'd3)) begin
            // End jingle preempts any other tone with no gap.
            w_pick = 4'b1000;
          end else if (r_cnt == 32'd0) begin
            w_state_nxt = ST_GAP;
            w_cnt_nxt   = L_GAP;
          end else begin
            w_cnt_nxt = r_cnt - 32'd1;
          end
        end
        ST_GAP: begin
          if (r_cnt == 32'd0) begin
            // Last silent cycle: chain into the best pending tone.
            w_pick = f_pick_hi(w_queued);
            if (w_pick == 4'b0000) begin
              w_state_nxt = ST_IDLE;
            end else begin
              w_state_nxt = ST_PLAY;
            end
          end else begin
            w_cnt_nxt = r_cnt - 32'd1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 32'd0;
        end
      endcase

      if (w_pick != 4'b0000) begin
        w_state_nxt = ST_PLAY;
        w_cnt_nxt   = f_len(w_pick);
        w_grant_nxt = w_pick;
        w_sel_nxt   = f_sel(w_pick);
      end else begin
        w_grant_nxt = 4'b0000;
      end

      // A granted source clears its flag; every other request (including
      // a repeat of the tone now playing) is remembered as one flag.
      w_pend_nxt = w_queued & ~w_pick;
    end
  end

  // State, duration counter and pending flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 32'd0;
      r_pend  <= 4'b0000;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  // Registered outputs, derived from the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tone_on  <= 1'b0;
      r_busy     <= 1'b0;
      r_grant    <= 4'b0000;
      r_tone_sel <= 2'd0;
    end else begin
      r_tone_on  <= (w_state_nxt == ST_PLAY);
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_grant    <= w_grant_nxt;
      r_tone_sel <= w_sel_nxt;
    end
  end

  // The pending flag of the end source is only ever set while the end
  // tone itself is playing or during a gap; B_END documents the layout.
  assign tone_on  = r_tone_on;
  assign tone_sel = r_tone_sel;
  assign grant    = r_grant & {4{B_END == 3}};
  assign busy     = r_busy;

endmodule

// File: tb/tb_sound_arbiter.sv
// Directed bench for sound_arbiter with short tone lengths.
// Expected outputs follow the queue-on or queue-off behaviour depending on
// whether SOUND_QUEUE_EN is defined for the build.

module tb_sound_arbiter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       req_end;
  logic       req_goal;
  logic       req_sgoal;
  logic       req_cnt;
  logic       tone_on;
  logic [1:0] tone_sel;
  logic [3:0] grant;
  logic       busy;

  int n_checks;
  int n_err;

  sound_arbiter #(
    .GOAL_CYC(32'd4),
    .CNT_CYC (32'd2),
    .END_CYC (32'd6),
    .GAP_CYC (32'd1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .req_end  (req_end),
    .req_goal (req_goal),
    .req_sgoal(req_sgoal),
    .req_cnt  (req_cnt),
    .tone_on  (tone_on),
    .tone_sel (tone_sel),
    .grant    (grant),
    .busy     (busy)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus and the outputs expected after the next edge,
  // packed as {tone_on, busy, grant[3:0], tone_sel[1:0]}.
  typedef struct {
    string      tag;
    logic       en;
    logic [3:0] req;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string t, input logic e, input logic [3:0] r,
                     input logic to, input logic bu, input logic [3:0] g,
                     input logic [1:0] s);
    vec_t v;
    v.tag = t;
    v.en  = e;
    v.req = r;
    v.exp = {to, bu, g, s};
    vecs.push_back(v);
  endtask

  task automatic check(input string t, input logic [7:0] exp);
    logic [7:0] got;
    got = {tone_on, busy, grant, tone_sel};
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got tone_on=%b busy=%b grant=%b tone_sel=%0d, expected tone_on=%b busy=%b grant=%b tone_sel=%0d",
               t, got[7], got[6], got[5:2], got[1:0], exp[7], exp[6], exp[5:2], exp[1:0]);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_err     = 0;
    rst       = 1'b1;
    en        = 1'b1;
    req_end   = 1'b0;
    req_goal  = 1'b1;
    req_sgoal = 1'b0;
    req_cnt   = 1'b0;

    // ---- vector table ----
    // Single goal tone: 4 on, 1 gap, idle.
    add("goal_start", 1'b1, 4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2);
    for (int i = 0; i < 3; i++) add("goal_tone", 1'b1, 4'b0000, 1'b1, 1'b1, 4'b0000, 2'd2);
    add("goal_gap",  1'b1, 4'b0000, 1'b0, 1'b1, 4'b0000, 2'd2);
    add("goal_idle", 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd2);

    // goal and cnt together: goal wins.
    add("gc_goal_start", 1'b1, 4'b0101, 1'b1, 1'b1, 4'b0100, 2'd2);
    for (int i = 0; i < 3; i++) add("gc_goal_tone", 1'b1, 4'b0000, 1'b1, 1'b1, 4'b0000, 2'd2);
    add("gc_gap", 1'b1, 4'b0000, 1'b0, 1'b1, 4'b0000, 2'd2);
`ifdef SOUND_QUEUE_EN
    add("gc_cnt_start", 1'b1, 4'b0000, 1'b1, 1'b1, 4'b0001, 2'd0);
    add("gc_cnt_tone",  1'b1, 4'b0000, 1'b1, 1'b1, 4'b0000, 2'd0);
    add("gc_cnt_gap",   1'b1, 4'b0000, 1'b0, 1'b1, 4'b0000, 2'd0);
    add("gc_idle",      1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0);
`else
    for (int i = 0; i < 4; i++) add("gc_cnt_dropped", 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd2);
`endif

    // end preempts goal on its 2nd cycle; a repeat end does not restart.
    add("pre_goal_start", 1'b1, 4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2);
    add("pre_end_start",  1'b1, 4'b1000, 1'b1, 1'b1, 4'b1000, 2'd3);
    add("pre_end_tone",   1'b1, 4'b0000, 1'b1, 1'b1, 4'b0000, 2'd3);
    add("pre_end_repeat", 1'b1, 4'b1000, 1'b1, 1'b1, 4'b0000, 2'd3);
    for (int i = 0; i < 3; i++) add("pre_end_tone", 1'b1, 4'b0000, 1'b1, 1'b1, 4'b0000, 2'd3);
    add("pre_gap", 1'b1, 4'b0000, 1'b0, 1'b1, 4'b0000, 2'd3);
`ifdef SOUND_QUEUE_EN
    add("pre_end_replay", 1'b1, 4'b0000, 1'b1, 1'b1, 4'b1000, 2'd3);
    for (int i = 0; i < 5; i++) add("pre_replay_tone", 1'b1, 4'b0000, 1'b1, 1'b1, 4'b0000, 2'd3);
    add("pre_replay_gap", 1'b1, 4'b0000, 1'b0, 1'b1, 4'b0000, 2'd3);
`endif
    add("pre_idle", 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd3);

    // Three sgoal pulses during a goal tone collapse into one.
    add("sg_goal_start", 1'b1, 4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2);
    for (int i = 0; i < 3; i++) add("sg_pulse", 1'b1, 4'b0010, 1'b1, 1'b1, 4'b0000, 2'd2);
    add("sg_gap", 1'b1, 4'b0000, 1'b0, 1'b1, 4'b0000, 2'd2);
`ifdef SOUND_QUEUE_EN
    add("sg_start", 1'b1, 4'b0000, 1'b1, 1'b1, 4'b0010, 2'd1);
    for (int i = 0; i < 3; i++) add("sg_tone", 1'b1, 4'b0000, 1'b1, 1'b1, 4'b0000, 2'd1);
    add("sg_gap2", 1'b1, 4'b0000, 1'b0, 1'b1, 4'b0000, 2'd1);
    add("sg_idle", 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd1);
    add("sg_idle", 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd1);
`else
    for (int i = 0; i < 2; i++) add("sg_dropped", 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd2);
`endif

    // en dropped mid-tone flushes a pending cnt; requests ignored while off.
    add("en_goal_start", 1'b1, 4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2);
    add("en_cnt_busy",   1'b1, 4'b0001, 1'b1, 1'b1, 4'b0000, 2'd2);
    add("en_off",        1'b0, 4'b0100, 1'b0, 1'b0, 4'b0000, 2'd2);
    add("en_off_req",    1'b0, 4'b0001, 1'b0, 1'b0, 4'b0000, 2'd2);
    for (int i = 0; i < 3; i++) add("en_back_idle", 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd2);

    // Same-cycle burst of all four: end wins.
    add("all4_end_start", 1'b1, 4'b1111, 1'b1, 1'b1, 4'b1000, 2'd3);
    add("all4_en_off",    1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd3);

    // ---- reset state (request held during reset is ignored) ----
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 8'h00);
    req_goal = 1'b0;
    rst      = 1'b0;

    // ---- table loop ----
    foreach (vecs[i]) begin
      en = vecs[i].en;
      {req_end, req_goal, req_sgoal, req_cnt} = vecs[i].req;
      @(posedge clk);
      #1;
      check(vecs[i].tag, vecs[i].exp);
    end
    en = 1'b1;
    {req_end, req_goal, req_sgoal, req_cnt} = 4'b0000;
    @(posedge clk);
    #1;

    // ---- asynchronous reset in the gap, then first request after release ----
    req_goal = 1'b1;
    @(posedge clk);
    #1;
    req_goal = 1'b0;
    check("rg_goal_start", {1'b1, 1'b1, 4'b0100, 2'd2});
    repeat (4) @(posedge clk);
    #1;
    check("rg_gap", {1'b0, 1'b1, 4'b0000, 2'd2});
    #3;
    rst = 1'b1;
    #1;
    check("rg_async_reset", 8'h00);
    #1;
    rst     = 1'b0;
    req_cnt = 1'b1;
    @(posedge clk);
    #1;
    req_cnt = 1'b0;
    check("rg_first_req", {1'b1, 1'b1, 4'b0001, 2'd0});
    @(posedge clk);
    #1;
    check("rg_cnt_tone", {1'b1, 1'b1, 4'b0000, 2'd0});
    @(posedge clk);
    #1;
    check("rg_cnt_gap", {1'b0, 1'b1, 4'b0000, 2'd0});
    @(posedge clk);
    #1;
    check("rg_idle", {1'b0, 1'b0, 4'b0000, 2'd0});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
